// File: rtl/smvm_pkg.sv
// Shared definitions for the sparse matrix-vector datapath: lane count, field widths
// and the nonzero scheduler state encoding.
package smvm_pkg;

    localparam int unsigned NUM_CHANNELS_DEF = 4;
    localparam int unsigned ROW_W_DEF        = 16;
    localparam int unsigned LANE_W           = 32;

    typedef enum logic [2:0] {
        IDLE,
        GET_LEN,
        GET_ELEM,
        ISSUE,
        WAIT,
        EMIT
    } state_e;

endpackage

// File: rtl/nnz_scheduler_if.sv
// Job control, row-length/element streams, multiplier port and descriptor output of
// the nonzero scheduler; slave is the scheduler's view, master the environment's.
interface nnz_scheduler_if import smvm_pkg::*; #(
    parameter int unsigned NUM_CHANNELS = NUM_CHANNELS_DEF,
    parameter int unsigned ROW_W        = ROW_W_DEF
) ();
    logic                                      start;
    logic [ROW_W-1:0]                          num_rows;
    logic                                      len_valid;
    logic                                      len_ready;
    logic [ROW_W-1:0]                          len_data;
    logic                                      elem_valid;
    logic                                      elem_ready;
    logic [NUM_CHANNELS-1:0][LANE_W-1:0]       elem_values;
    logic [NUM_CHANNELS-1:0][LANE_W-1:0]       elem_cols;
    logic [NUM_CHANNELS-1:0][LANE_W-1:0]       mul_values;
    logic [NUM_CHANNELS-1:0][LANE_W-1:0]       mul_cols;
    logic                                      mul_start;
    logic                                      mul_done;
    logic                                      out_valid;
    logic                                      out_ready;
    logic [NUM_CHANNELS-1:0]                   out_mask;
    logic                                      out_row_last;
    logic [ROW_W-1:0]                          out_row_idx;
    logic                                      busy;
    logic                                      done;

    modport slave (
        input  start, num_rows, len_valid, len_data, elem_valid, elem_values, elem_cols,
               mul_done, out_ready,
        output len_ready, elem_ready, mul_values, mul_cols, mul_start, out_valid,
               out_mask, out_row_last, out_row_idx, busy, done
    );

    modport master (
        output start, num_rows, len_valid, len_data, elem_valid, elem_values, elem_cols,
               mul_done, out_ready,
        input  len_ready, elem_ready, mul_values, mul_cols, mul_start, out_valid,
               out_mask, out_row_last, out_row_idx, busy, done
    );
endinterface

// File: rtl/lane_mask_gen.sv
// Maps the remaining nonzero count of a row to the valid-lane mask of the next batch
// and whether that batch closes the row.
module lane_mask_gen import smvm_pkg::*; #(
    parameter int unsigned NUM_CHANNELS = NUM_CHANNELS_DEF,
    parameter int unsigned ROW_W        = ROW_W_DEF
) (
    input  logic [ROW_W-1:0]        rem,
    output logic [NUM_CHANNELS-1:0] mask_c,
    output logic                    row_last_c
);
    always_comb begin
        mask_c = '0;
        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            mask_c[k] = ROW_W'(k) < rem;
        end
        row_last_c = rem <= ROW_W'(NUM_CHANNELS);
    end
endmodule

// File: rtl/nnz_scheduler.sv
// Walks a CSR job row by row: fetches each row length, feeds NUM_CHANNELS-wide element
// batches to a single multiplier one at a time, and emits a lane descriptor per batch.
module nnz_scheduler import smvm_pkg::*; #(
    parameter int unsigned NUM_CHANNELS = NUM_CHANNELS_DEF,
    parameter int unsigned ROW_W        = ROW_W_DEF
) (
    input  logic           clk,
    input  logic           rst_l,
    nnz_scheduler_if.slave bus
);
    localparam logic [ROW_W-1:0] NC_W = ROW_W'(NUM_CHANNELS);

    typedef logic [NUM_CHANNELS-1:0][LANE_W-1:0] lanes_t;

    state_e                  state_q, state_d;
    logic [ROW_W-1:0]        rem_q, rem_d;
    logic [ROW_W-1:0]        row_idx_q, row_idx_d;
    logic [ROW_W-1:0]        rows_q, rows_d;
    lanes_t                  mul_values_q, mul_values_d;
    lanes_t                  mul_cols_q, mul_cols_d;
    logic [NUM_CHANNELS-1:0] out_mask_q, out_mask_d;
    logic [ROW_W-1:0]        out_row_idx_q, out_row_idx_d;
    logic                    out_row_last_q, out_row_last_d;
    logic                    len_ready_q, len_ready_d;
    logic                    elem_ready_q, elem_ready_d;
    logic                    mul_start_q, mul_start_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [NUM_CHANNELS-1:0] lane_mask_c;
    logic                    row_last_c;

    lane_mask_gen #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .ROW_W        (ROW_W)
    ) u_lane_mask_gen (
        .rem        (rem_q),
        .mask_c     (lane_mask_c),
        .row_last_c (row_last_c)
    );

    // Next state; every output flop is derived from the state being entered.
    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        row_idx_d      = row_idx_q;
        rows_d         = rows_q;
        mul_values_d   = mul_values_q;
        mul_cols_d     = mul_cols_q;
        out_mask_d     = out_mask_q;
        out_row_last_d = out_row_last_q;
        done_d         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.num_rows != '0) begin
                        rows_d    = bus.num_rows;
                        row_idx_d = '0;
                        state_d   = GET_LEN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            GET_LEN: begin
                if (bus.len_valid && len_ready_q) begin
                    rem_d = bus.len_data;
                    if (bus.len_data == '0) begin
                        out_mask_d     = '0;
                        out_row_last_d = 1'b1;
                        state_d        = EMIT;
                    end else begin
                        state_d = GET_ELEM;
                    end
                end
            end
            GET_ELEM: begin
                if (bus.elem_valid && elem_ready_q) begin
                    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
                        mul_values_d[k] = lane_mask_c[k] ? bus.elem_values[k] : '0;
                        mul_cols_d[k]   = lane_mask_c[k] ? bus.elem_cols[k]   : '0;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.mul_done) begin
                    out_mask_d     = lane_mask_c;
                    out_row_last_d = row_last_c;
                    state_d        = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready && out_valid_q) begin
                    out_mask_d     = '0;
                    out_row_last_d = 1'b0;
                    if (!row_last_c) begin
                        rem_d   = rem_q - NC_W;
                        state_d = GET_ELEM;
                    end else begin
                        rem_d = '0;
                        if (row_idx_q == rows_q - ROW_W'(1)) begin
                            row_idx_d = '0;
                            done_d    = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            row_idx_d = row_idx_q + ROW_W'(1);
                            state_d   = GET_LEN;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        len_ready_d   = state_d == GET_LEN;
        elem_ready_d  = state_d == GET_ELEM;
        mul_start_d   = state_d == ISSUE;
        out_valid_d   = state_d == EMIT;
        busy_d        = state_d != IDLE;
        out_row_idx_d = row_idx_d;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q        <= IDLE;
            rem_q          <= '0;
            row_idx_q      <= '0;
            rows_q         <= '0;
            mul_values_q   <= '0;
            mul_cols_q     <= '0;
            out_mask_q     <= '0;
            out_row_idx_q  <= '0;
            out_row_last_q <= 1'b0;
            len_ready_q    <= 1'b0;
            elem_ready_q   <= 1'b0;
            mul_start_q    <= 1'b0;
            out_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            row_idx_q      <= row_idx_d;
            rows_q         <= rows_d;
            mul_values_q   <= mul_values_d;
            mul_cols_q     <= mul_cols_d;
            out_mask_q     <= out_mask_d;
            out_row_idx_q  <= out_row_idx_d;
            out_row_last_q <= out_row_last_d;
            len_ready_q    <= len_ready_d;
            elem_ready_q   <= elem_ready_d;
            mul_start_q    <= mul_start_d;
            out_valid_q    <= out_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign bus.len_ready    = len_ready_q;
    assign bus.elem_ready   = elem_ready_q;
    assign bus.mul_values   = mul_values_q;
    assign bus.mul_cols     = mul_cols_q;
    assign bus.mul_start    = mul_start_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_mask     = out_mask_q;
    assign bus.out_row_last = out_row_last_q;
    assign bus.out_row_idx  = out_row_idx_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_nnz_scheduler.sv
// Bench for nnz_scheduler: directed jobs plus random jobs, checked against a per-row
// batch list computed from row lengths.
module tb_nnz_scheduler;
    import smvm_pkg::*;

    localparam int unsigned NC = 4;
    localparam int unsigned RW = 16;

    typedef logic [NC-1:0][31:0] lanes_t;
    typedef struct {
        lanes_t vals;
        lanes_t cols;
    } elem_t;
    typedef struct {
        lanes_t        vals;
        lanes_t        cols;
        logic [NC-1:0] mask;
        bit            last;
        int            idx;
        bit            has_mul;
    } desc_t;

    logic clk = 1'b0;
    logic rst_l;
    int   total = 0;
    int   bad   = 0;
    int   job_lens[$];

    always #5 clk = ~clk;

    nnz_scheduler_if #(.NUM_CHANNELS(NC), .ROW_W(RW)) bus ();

    nnz_scheduler #(.NUM_CHANNELS(NC), .ROW_W(RW)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.num_rows = '0;
        bus.len_valid = 1'b0; bus.len_data = '0;
        bus.elem_valid = 1'b0; bus.elem_values = '0; bus.elem_cols = '0;
        bus.mul_done = 1'b0; bus.out_ready = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_flags"}, 256'({bus.busy, bus.done, bus.len_ready, bus.elem_ready,
              bus.mul_start, bus.out_valid, bus.out_row_last}), 256'(0));
        check({tag, "_mask_idx"}, 256'({bus.out_mask, bus.out_row_idx}), 256'(0));
        check({tag, "_operands"}, 256'({bus.mul_values, bus.mul_cols}), 256'(0));
    endtask

    // force_stall < 0 picks a random out_ready delay per descriptor
    task automatic run_job(input int force_stall, input bit busy_start);
        elem_t  elem_q[$];
        desc_t  exp_q[$];
        int     len_q[$];
        int     n, lat, stall, mul_cnt;
        bit     finished, outstanding, in_emit, done_exp, done_next;
        lanes_t held_v, held_c;
        logic [NC+RW:0] obs_desc;

        n = job_lens.size();
        foreach (job_lens[r]) begin
            int rem;
            rem = job_lens[r];
            len_q.push_back(rem);
            if (rem == 0) begin
                desc_t d;
                d.vals = '0; d.cols = '0; d.mask = '0; d.last = 1'b1; d.idx = r; d.has_mul = 1'b0;
                exp_q.push_back(d);
            end
            while (rem > 0) begin
                elem_t e;
                desc_t d;
                int    k;
                k = (rem < int'(NC)) ? rem : int'(NC);
                for (int l = 0; l < int'(NC); l++) begin
                    e.vals[l] = $urandom();
                    e.cols[l] = $urandom();
                end
                d.vals = '0; d.cols = '0;
                for (int l = 0; l < k; l++) begin
                    d.vals[l] = e.vals[l];
                    d.cols[l] = e.cols[l];
                end
                d.mask = NC'((1 << k) - 1);
                d.last = rem <= int'(NC);
                d.idx = r;
                d.has_mul = 1'b1;
                elem_q.push_back(e);
                exp_q.push_back(d);
                rem -= k;
            end
        end

        @(negedge clk);
        bus.start = 1'b1;
        bus.num_rows = RW'(n);
        finished = 0; outstanding = 0; lat = 0; in_emit = 0; stall = 0; mul_cnt = 0;
        done_next = 0; held_v = '0; held_c = '0; obs_desc = '0;

        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.out_ready = 1'b0;
            if (bus.mul_done) begin
                bus.mul_done = 1'b0;
                outstanding = 0;
            end
            if (cyc == 0) check("busy_after_start", 256'(bus.busy), 256'(1));
            done_exp = done_next;
            done_next = 0;
            check("done_pulse", 256'(bus.done), 256'(done_exp));
            if (done_exp) begin
                check("busy_after_done", 256'(bus.busy), 256'(0));
                finished = 1;
            end
            if (busy_start && cyc == 2 && bus.busy) begin
                bus.start = 1'b1;
                bus.num_rows = RW'(5);
            end

            // multiplier model: single outstanding op, operands held until done
            if (bus.mul_start) begin
                check("mul_single_outstanding", 256'(outstanding), 256'(0));
                outstanding = 1;
                mul_cnt++;
                lat = $urandom_range(1, 4);
                held_v = bus.mul_values;
                held_c = bus.mul_cols;
                if (exp_q.size() > 0) begin
                    check("mul_values", 256'(bus.mul_values), 256'(exp_q[0].vals));
                    check("mul_cols", 256'(bus.mul_cols), 256'(exp_q[0].cols));
                end
            end else if (outstanding) begin
                check("mul_operands_hold", 256'({bus.mul_values, bus.mul_cols}), 256'({held_v, held_c}));
                lat--;
                if (lat == 0) bus.mul_done = 1'b1;
            end

            if (bus.out_valid) begin
                if (!in_emit) begin
                    in_emit = 1;
                    stall = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
                    obs_desc = {bus.out_mask, bus.out_row_last, bus.out_row_idx};
                    check("desc_available", 256'(exp_q.size() > 0), 256'(1));
                    if (exp_q.size() > 0) begin
                        check("out_mask", 256'(bus.out_mask), 256'(exp_q[0].mask));
                        check("out_row_last", 256'(bus.out_row_last), 256'(exp_q[0].last));
                        check("out_row_idx", 256'(bus.out_row_idx), 256'(exp_q[0].idx));
                        check("mul_per_batch", 256'(mul_cnt), 256'(exp_q[0].has_mul));
                    end
                end else begin
                    check("desc_stable", 256'({bus.out_mask, bus.out_row_last, bus.out_row_idx}),
                          256'(obs_desc));
                    check("stall_quiet", 256'({bus.len_ready, bus.elem_ready, bus.mul_start}), 256'(0));
                end
                if (stall == 0) begin
                    bus.out_ready = 1'b1;
                    in_emit = 0;
                    mul_cnt = 0;
                    if (exp_q.size() > 0) exp_q.delete(0);
                    if (exp_q.size() == 0) done_next = 1;
                end else begin
                    stall--;
                end
            end

            bus.len_valid = (len_q.size() > 0) && ($urandom_range(0, 3) != 0);
            if (len_q.size() > 0) bus.len_data = RW'(len_q[0]);
            if (bus.len_valid && bus.len_ready) len_q.delete(0);

            bus.elem_valid = (elem_q.size() > 0) && ($urandom_range(0, 3) != 0);
            if (elem_q.size() > 0) begin
                bus.elem_values = elem_q[0].vals;
                bus.elem_cols = elem_q[0].cols;
            end
            if (bus.elem_valid && bus.elem_ready) elem_q.delete(0);
        end

        check("job_completes", 256'(finished), 256'(1));
        check("streams_drained", 256'(len_q.size() + elem_q.size()), 256'(0));
        idle_inputs();
    endtask

    initial begin
        bit seen;
        rst_l = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check_reset_outs("por");
        rst_l = 1'b1;

        // zero-row job: done pulse only, len stream never accepted
        @(negedge clk);
        bus.start = 1'b1; bus.num_rows = '0; bus.len_valid = 1'b1; bus.len_data = RW'(3);
        @(negedge clk);
        bus.start = 1'b0;
        check("zero_rows_done", 256'(bus.done), 256'(1));
        check("zero_rows_busy", 256'(bus.busy), 256'(0));
        check("zero_rows_no_hs", 256'({bus.len_ready, bus.elem_ready}), 256'(0));
        @(negedge clk);
        check("zero_rows_done_once", 256'(bus.done), 256'(0));
        check("zero_rows_no_hs2", 256'({bus.len_ready, bus.elem_ready}), 256'(0));
        bus.len_valid = 1'b0;

        job_lens.delete(); job_lens.push_back(4);
        run_job(0, 0);
        job_lens.delete(); job_lens.push_back(6);
        run_job(-1, 0);
        job_lens.delete(); job_lens.push_back(0); job_lens.push_back(3);
        run_job(-1, 0);
        job_lens.delete(); job_lens.push_back(5); job_lens.push_back(2);
        run_job(5, 1);

        // reset while the multiplier is outstanding
        @(negedge clk);
        bus.start = 1'b1; bus.num_rows = RW'(1);
        @(negedge clk);
        bus.start = 1'b0; bus.len_valid = 1'b1; bus.len_data = RW'(8);
        bus.elem_valid = 1'b1;
        for (int l = 0; l < int'(NC); l++) begin
            bus.elem_values[l] = $urandom();
            bus.elem_cols[l] = $urandom();
        end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.mul_start) seen = 1;
        end
        check("rst_reach_issue", 256'(seen), 256'(1));
        bus.len_valid = 1'b0; bus.elem_valid = 1'b0;
        @(negedge clk);
        check("rst_in_wait_busy", 256'(bus.busy), 256'(1));
        #2 rst_l = 1'b0;
        #1;
        check_reset_outs("rst_wait");
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        check("rst_no_done", 256'({bus.done, bus.busy}), 256'(0));

        job_lens.delete(); job_lens.push_back(2); job_lens.push_back(7);
        run_job(-1, 0);

        for (int j = 0; j < 25; j++) begin
            int nrows;
            nrows = $urandom_range(1, 4);
            job_lens.delete();
            for (int r = 0; r < nrows; r++) job_lens.push_back(int'($urandom_range(0, 11)));
            run_job(-1, bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
